up_hst_bridge: RTL
==================

# up_hst_bridge

Host-to-up-protocol bridge sitting directly upstream of the configuration-RAM macros (`up_ramcfg_*`) and other up-protocol register slaves. It accepts single-word host read/write commands, decodes the upper address bits to one of G_NSLV slaves, and drives that slave's `upen`/`upa`/`upws`/`uprs`/`updi`. It then waits for `uprdy` (returned data on `updo`), applies a timeout, and returns data or error status to the host. One transaction in flight at a time.

## Interface
- G_ADDR, 10: slave word-address width (`upa`)
- G_WIDTH, 32: data width
- G_SBIT, 2: slave-select bits, taken from `hst_addr[G_ADDR+G_SBIT-1:G_ADDR]`
- G_NSLV, 4: number of slaves, 1..2^G_SBIT
- G_TMO, 64: timeout in cycles, ≥4, <2^16
- clk  in  1  clock
- rst_n  in  1  reset; **one clock; reset is asynchronous and active-low**
- hst_req  in  1  single-cycle command strobe, honoured only when `hst_busy`=0
- hst_wr  in  1  1=write, 0=read; sampled with `hst_req`
- hst_addr  in  G_ADDR+G_SBIT  slave index plus word address
- hst_wdat  in  G_WIDTH  write data
- hst_busy  out  1  transaction in progress or flush pending
- hst_ack  out  1  one-cycle completion pulse
- hst_rdat  out  G_WIDTH  read data, valid with `hst_ack`, held until next ack
- hst_err  out  1  valid with `hst_ack`: 1 = bad slave index or timeout
- upen  out  G_NSLV  one-hot slave enable
- upa  out  G_ADDR  shared slave address
- upws / uprs  out  1  shared write/read strobes
- updi  out  G_WIDTH  shared write data
- updo  in  G_NSLV*G_WIDTH  slave read data, slave k at bits [k*G_WIDTH +: G_WIDTH]
- uprdy  in  G_NSLV  per-slave ready

## Operation
- All outputs registered; reset value 0 for every output; FSM resets to IDLE.
- States: IDLE, STRB, WAIT, FLUSH.
- IDLE: `hst_req`=1 latches `hst_wr`, address and data and sets `hst_busy`. Index ≥ G_NSLV: no up access; `hst_ack`=1, `hst_err`=1, `hst_rdat`=0 next cycle; stay IDLE. Otherwise go to STRB.
- STRB (one cycle): `upen[idx]`=1, `upa`, `updi` driven; exactly one of `upws`/`uprs` = 1. Go to WAIT.
- WAIT: `upen[idx]` held 1, strobes 0, `upa`/`updi` held. Only `uprdy[idx]` and `updo[idx]` are observed; other slaves' `uprdy` are ignored.
  - `uprdy[idx]`=1: capture `updo[idx]` (reads; writes capture 0); `hst_ack`=1, `hst_err`=0 next cycle; `upen`=0; go to IDLE.
  - Timeout: `hst_ack`=1, `hst_err`=1, `hst_rdat`=0; `upen`=0; go to FLUSH.
- FLUSH: two cycles with `upen`=0 and `hst_busy`=1. Late `uprdy` from the abandoned access, which arrives ≤2 cycles after the slave's final accept, is discarded. Then go to IDLE.
- `hst_busy` deasserts in the same cycle `hst_ack` asserts on a normal or decode-error completion, so back-to-back commands are possible.
- `hst_req` while `hst_busy`=1 is dropped silently; no queueing.
- Strobes are single-cycle by design: the slave macros act on every `upen&upws` cycle. A held strobe would cause repeated writes and repeated `uprdy`.

## Timing
- Timeout counter: cleared on entry to STRB; counts STRB as cycle 1; expires at cycle G_TMO without `uprdy[idx]`. If `uprdy[idx]` arrives on the expiry cycle, the transaction succeeds.
- With a 2-cycle slave (`up_ramcfg`, no engine contention), `hst_req` at T0 gives: STRB at T1, `uprdy` at T3, `hst_ack` at T4. Normal latency is 4 cycles.
- Engine contention on a read stretches WAIT; the latency is then 4 + stall cycles.
- Decode error: `hst_ack` at T1.
- Reset mid-transaction: all outputs go to 0 immediately; `upen`=0 lets the slave clear its read latch. Nothing pending survives reset.

## Structure
- Shared header `up_defs.vh`: FSM state encodings (2-bit), FLUSH length constant (2), error code bit positions.
- Sub-module `up_tmo_cnt`: loadable 16-bit down-counter with clear, enable and `expire` output. Other flops use `s_dff`.
- Top module: address decode, one-hot `upen` generation, `updo` mux, FSM, result registers.

## Test plan
- Write, slave 1, addr 0x005, data 0xDEADBEEF, `uprdy` at T3: exactly one `upws` cycle; `hst_ack`=1, `hst_err`=0 at T4; `hst_busy` 0 at T4.
- Read, slave 0, addr 0x005, slave returns 0x12345678 with `uprdy` 4 cycles late: `upen[0]` held through WAIT, one `uprs` cycle; `hst_rdat`=0x12345678, `hst_err`=0.
- G_NSLV=3, `hst_addr` index 3: `hst_ack`=1, `hst_err`=1 at T1; `upen` stays 0.
- G_TMO=16, no `uprdy`: `hst_err`=1 on ack; `upen` drops; a stray `uprdy` 1 cycle later is ignored; `hst_busy`=0 two cycles after ack.
- `uprdy` exactly on the expiry cycle → success, `hst_err`=0. `hst_req` during busy → ignored, no second access.
- `rst_n` low during WAIT: all outputs 0 asynchronously; after release, a new read completes normally.

Source files
------------

// File: rtl/up_hst_bridge_pkg.sv
// -----------------------------------------------------------------------------
// up_hst_bridge_pkg
// Shared definitions for the host-to-up-protocol bridge:
//   - state_t   : 2-bit FSM state encoding (IDLE, STRB, WAIT, FLUSH)
//   - FLUSH_LEN : number of cycles spent discarding late uprdy after a timeout
//   - TMO_W     : width of the timeout down-counter
// -----------------------------------------------------------------------------
package up_hst_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_STRB  = 2'b01,
        S_WAIT  = 2'b10,
        S_FLUSH = 2'b11
    } state_t;

    localparam logic [1:0] FLUSH_LEN = 2'd2;
    localparam int         TMO_W     = 16;

endpackage

// File: rtl/up_hst_bridge_tmo_cnt.sv
// -----------------------------------------------------------------------------
// up_hst_bridge_tmo_cnt
// Loadable down-counter used as the transaction timeout.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force count to zero (highest priority)
//   load       : load load_val
//   en         : decrement by one (saturates at zero)
//   load_val   : value loaded on load
//   expire     : count is zero
// -----------------------------------------------------------------------------
module up_hst_bridge_tmo_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/up_hst_bridge.sv
// -----------------------------------------------------------------------------
// up_hst_bridge
// Bridges single-word host read/write commands onto the up-protocol used by
// configuration-RAM macros and register slaves. One transaction in flight.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   hst_req/wr/addr/wdat : host command (strobe, direction, {index,addr}, data)
//   hst_busy             : transaction in progress or flush pending
//   hst_ack/rdat/err     : one-cycle completion, read data, error flag
//   upen                 : one-hot slave enable
//   upa/upws/uprs/updi   : shared slave address, write/read strobes, data
//   updo/uprdy           : per-slave read data and ready
// All outputs are registered and reset to zero.
// -----------------------------------------------------------------------------
module up_hst_bridge
    import up_hst_bridge_pkg::*;
#(
    parameter int G_ADDR  = 10,
    parameter int G_WIDTH = 32,
    parameter int G_SBIT  = 2,
    parameter int G_NSLV  = 4,
    parameter int G_TMO   = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        hst_req,
    input  logic                        hst_wr,
    input  logic [G_ADDR+G_SBIT-1:0]    hst_addr,
    input  logic [G_WIDTH-1:0]          hst_wdat,
    output logic                        hst_busy,
    output logic                        hst_ack,
    output logic [G_WIDTH-1:0]          hst_rdat,
    output logic                        hst_err,
    output logic [G_NSLV-1:0]           upen,
    output logic [G_ADDR-1:0]           upa,
    output logic                        upws,
    output logic                        uprs,
    output logic [G_WIDTH-1:0]          updi,
    input  logic [G_NSLV*G_WIDTH-1:0]   updo,
    input  logic [G_NSLV-1:0]           uprdy
);

    state_t              state, state_nxt;
    logic                busy_nxt, ack_nxt, err_nxt, ws_nxt, rs_nxt;
    logic                wr_q, wr_nxt;
    logic [G_WIDTH-1:0]  rdat_nxt, updi_nxt, do_sel;
    logic [G_NSLV-1:0]   upen_nxt, req_sel;
    logic [G_ADDR-1:0]   upa_nxt;
    logic [1:0]          fcnt, fcnt_nxt;
    logic                rdy_sel;
    logic                tmo_load, tmo_en, tmo_clr, tmo_exp;
    logic [G_SBIT-1:0]   req_idx;

    assign req_idx = hst_addr[G_ADDR+G_SBIT-1:G_ADDR];

    // An index >= G_NSLV yields an all-zero select, which doubles as the
    // decode-error indication.
    always_comb begin
        req_sel = '0;
        for (int k = 0; k < G_NSLV; k++) begin
            req_sel[k] = (req_idx == k[G_SBIT-1:0]);
        end
    end

    // upen is held one-hot for the whole access, so it selects the slave
    // whose ready/data are observed; every other slave is masked off.
    always_comb begin
        rdy_sel = 1'b0;
        do_sel  = '0;
        for (int k = 0; k < G_NSLV; k++) begin
            if (upen[k]) begin
                rdy_sel = rdy_sel | uprdy[k];
                do_sel  = do_sel | updo[k*G_WIDTH +: G_WIDTH];
            end
        end
    end

    // STRB is cycle 1 of the timeout window, so the counter is loaded with
    // G_TMO-1 and reaches zero on cycle G_TMO.
    up_hst_bridge_tmo_cnt #(
        .W (TMO_W)
    ) u_tmo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tmo_clr),
        .load     (tmo_load),
        .en       (tmo_en),
        .load_val (TMO_W'(G_TMO - 1)),
        .expire   (tmo_exp)
    );

    always_comb begin
        state_nxt = state;
        busy_nxt  = hst_busy;
        ack_nxt   = 1'b0;
        err_nxt   = hst_err;
        rdat_nxt  = hst_rdat;
        upen_nxt  = upen;
        upa_nxt   = upa;
        updi_nxt  = updi;
        ws_nxt    = 1'b0;
        rs_nxt    = 1'b0;
        wr_nxt    = wr_q;
        fcnt_nxt  = fcnt;
        tmo_load  = 1'b0;
        tmo_en    = 1'b0;
        tmo_clr   = 1'b0;

        case (state)
            S_IDLE: begin
                if (hst_req) begin
                    if (req_sel == '0) begin
                        ack_nxt  = 1'b1;
                        err_nxt  = 1'b1;
                        rdat_nxt = '0;
                    end else begin
                        state_nxt = S_STRB;
                        busy_nxt  = 1'b1;
                        upen_nxt  = req_sel;
                        upa_nxt   = hst_addr[G_ADDR-1:0];
                        updi_nxt  = hst_wdat;
                        ws_nxt    = hst_wr;
                        rs_nxt    = ~hst_wr;
                        wr_nxt    = hst_wr;
                        tmo_load  = 1'b1;
                    end
                end
            end

            S_STRB: begin
                state_nxt = S_WAIT;
                tmo_en    = 1'b1;
            end

            S_WAIT: begin
                // Ready wins over expiry when both land on the same cycle.
                if (rdy_sel) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                    ack_nxt   = 1'b1;
                    err_nxt   = 1'b0;
                    rdat_nxt  = wr_q ? '0 : do_sel;
                    upen_nxt  = '0;
                    tmo_clr   = 1'b1;
                end else if (tmo_exp) begin
                    state_nxt = S_FLUSH;
                    ack_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                    rdat_nxt  = '0;
                    upen_nxt  = '0;
                    fcnt_nxt  = '0;
                    tmo_clr   = 1'b1;
                end else begin
                    tmo_en = 1'b1;
                end
            end

            S_FLUSH: begin
                // upen is low here, so any late uprdy is masked by rdy_sel.
                if (fcnt == FLUSH_LEN - 2'd1) begin
                    state_nxt = S_IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    fcnt_nxt = fcnt + 2'd1;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            hst_busy <= 1'b0;
            hst_ack  <= 1'b0;
            hst_err  <= 1'b0;
            hst_rdat <= '0;
            upen     <= '0;
            upa      <= '0;
            updi     <= '0;
            upws     <= 1'b0;
            uprs     <= 1'b0;
            wr_q     <= 1'b0;
            fcnt     <= '0;
        end else begin
            state    <= state_nxt;
            hst_busy <= busy_nxt;
            hst_ack  <= ack_nxt;
            hst_err  <= err_nxt;
            hst_rdat <= rdat_nxt;
            upen     <= upen_nxt;
            upa      <= upa_nxt;
            updi     <= updi_nxt;
            upws     <= ws_nxt;
            uprs     <= rs_nxt;
            wr_q     <= wr_nxt;
            fcnt     <= fcnt_nxt;
        end
    end

endmodule
